// File: rtl/queue_frame_drain_pkg.sv
// queue_frame_drain shared definitions:
// FSM state encoding and Ethernet framing constants.
package queue_frame_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN_LO  = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int ETH_MIN_LEN     = 60;

endpackage

// File: rtl/queue_frame_drain_axis_out_reg.sv
// axis_out_reg: single-entry valid/ready output register
// carrying one data byte plus a last flag.
module axis_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       last_in,
    input  logic       m_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    output logic       slot_free
);

    assign slot_free = !m_tvalid || m_tready;

    // Load a new beat when free; otherwise hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata  <= 8'h00;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tdata  <= din;
            m_tvalid <= 1'b1;
            m_tlast  <= last_in;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/queue_frame_drain.sv
// queue_frame_drain: pops length-prefixed frames from the byte queue
// and streams payload to the MAC. Padding enabled by QUEUE_FRAME_DRAIN_PAD_EN.
module queue_frame_drain
    import queue_frame_drain_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int MIN_LEN   = ETH_MIN_LEN,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 q_rd_en,
    input  logic [7:0]           q_dout,
    input  logic                 q_empty,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 busy,
    output logic                 zero_len_err,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    localparam int HDR_W = 8 * FRAME_HDR_BYTES;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           len_hi;
    logic [LEN_WIDTH-1:0] rem;
    logic [LEN_WIDTH-1:0] hdr_len;
    logic [HDR_W-1:0]     hdr;
    logic                 rd_req;
    logic                 ld;
    logic [7:0]           ld_data;
    logic                 ld_last;
    logic                 zl_set;
    logic                 slot_free;

`ifdef QUEUE_FRAME_DRAIN_PAD_EN
    localparam logic [LEN_WIDTH:0] MIN_L = (LEN_WIDTH+1)'(MIN_LEN);
    logic [LEN_WIDTH-1:0] sent;
    logic [LEN_WIDTH:0]   sent_inc;
    assign sent_inc = {1'b0, sent} + (LEN_WIDTH+1)'(1);
`endif

    assign hdr     = {len_hi, q_dout};
    assign hdr_len = LEN_WIDTH'(hdr);
    assign q_rd_en = rd_req && !rst;
    assign busy    = (state != IDLE) || m_tvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, queue pop and output-register load decisions.
    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        ld        = 1'b0;
        ld_data   = 8'h00;
        ld_last   = 1'b0;
        zl_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!q_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (!q_empty) begin
                    rd_req = 1'b1;
                    if (hdr_len == '0) begin
                        zl_set    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!q_empty && slot_free) begin
                    rd_req  = 1'b1;
                    ld      = 1'b1;
                    ld_data = q_dout;
                    if (rem == LEN_WIDTH'(1)) begin
`ifdef QUEUE_FRAME_DRAIN_PAD_EN
                        if (sent_inc < MIN_L) begin
                            state_nxt = PAD;
                        end else begin
                            ld_last   = 1'b1;
                            state_nxt = IDLE;
                        end
`else
                        ld_last   = 1'b1;
                        state_nxt = IDLE;
`endif
                    end
                end
            end
            PAD: begin
`ifdef QUEUE_FRAME_DRAIN_PAD_EN
                if (slot_free) begin
                    ld = 1'b1;
                    if (sent_inc == MIN_L) begin
                        ld_last   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header capture, byte counters, error pulse and frame statistic.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi       <= 8'h00;
            rem          <= '0;
            zero_len_err <= 1'b0;
            frame_cnt    <= '0;
`ifdef QUEUE_FRAME_DRAIN_PAD_EN
            sent         <= '0;
`endif
        end else begin
            zero_len_err <= zl_set;
            if (state == IDLE && rd_req) begin
                len_hi <= q_dout;
            end
            if (state == LEN_LO && rd_req) begin
                rem <= hdr_len;
`ifdef QUEUE_FRAME_DRAIN_PAD_EN
                sent <= '0;
`endif
            end
            if (state == PAYLOAD && ld) begin
                rem <= rem - LEN_WIDTH'(1);
`ifdef QUEUE_FRAME_DRAIN_PAD_EN
                sent <= sent_inc[LEN_WIDTH-1:0];
`endif
            end
`ifdef QUEUE_FRAME_DRAIN_PAD_EN
            if (state == PAD && ld) begin
                sent <= sent_inc[LEN_WIDTH-1:0];
            end
`endif
            if (m_tvalid && m_tready && m_tlast) begin
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
        end
    end

    axis_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .din       (ld_data),
        .last_in   (ld_last),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .slot_free (slot_free)
    );

endmodule
